// File: rtl/vpg_pkg.sv
// Shared types and 1080p default timing for the video pattern generator timing path.
package vpg_pkg;

  localparam int VPG_CNT_W = 12;

  localparam int VPG_H_ACTIVE = 1920;
  localparam int VPG_H_FP     = 88;
  localparam int VPG_H_SYNC   = 44;
  localparam int VPG_H_BP     = 148;
  localparam int VPG_V_ACTIVE = 1080;
  localparam int VPG_V_FP     = 4;
  localparam int VPG_V_SYNC   = 5;
  localparam int VPG_V_BP     = 36;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vpg_tg_state_t;

endpackage

// File: rtl/vpg_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync window decode of
// the next count, so the parent can register outputs aligned with the count.
module vpg_axis_counter
  import vpg_pkg::*;
#(
  parameter int TOTAL      = 8,
  parameter int ACTIVE     = 4,
  parameter int SYNC_START = 5,
  parameter int SYNC_END   = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [VPG_CNT_W-1:0] count,
  output logic [VPG_CNT_W-1:0] count_nxt,
  output logic                 at_last,
  output logic                 act_nxt,
  output logic                 sync_nxt
);

  localparam int W = VPG_CNT_W;
  localparam logic [W-1:0] LAST_C = W'(TOTAL - 1);
  // Window bounds carry one extra bit so an end bound of 4096 stays representable.
  localparam logic [W:0] ACT_C = (W+1)'(ACTIVE);
  localparam logic [W:0] SS_C  = (W+1)'(SYNC_START);
  localparam logic [W:0] SE_C  = (W+1)'(SYNC_END);

  logic [W:0] cnt_ext;

  assign at_last = (count == LAST_C);

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc) begin
      count_nxt = at_last ? '0 : count + W'(1);
    end
  end

  assign cnt_ext  = {1'b0, count_nxt};
  assign act_nxt  = (cnt_ext < ACT_C);
  assign sync_nxt = (cnt_ext >= SS_C) && (cnt_ext < SE_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vpg_timing_gen.sv
// Video raster timing generator: counters, syncs, de and frame strobe; stops only at frame end.
// Optional `VPG_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output frame_cnt.
module vpg_timing_gen
  import vpg_pkg::*;
#(
  parameter int   H_ACTIVE = VPG_H_ACTIVE,
  parameter int   H_FP     = VPG_H_FP,
  parameter int   H_SYNC   = VPG_H_SYNC,
  parameter int   H_BP     = VPG_H_BP,
  parameter int   V_ACTIVE = VPG_V_ACTIVE,
  parameter int   V_FP     = VPG_V_FP,
  parameter int   V_SYNC   = VPG_V_SYNC,
  parameter int   V_BP     = VPG_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [VPG_CNT_W-1:0] h_count,
  output logic [VPG_CNT_W-1:0] v_count,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start,
  output logic                 busy
`ifdef VPG_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
    $error("vpg_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end

  vpg_tg_state_t        state, state_nxt;
  logic                 adv, clr, busy_nxt, last_px, fs_nxt;
  logic                 h_last, v_last, h_act, v_act, h_sync, v_sync;
  logic [VPG_CNT_W-1:0] h_nxt, v_nxt;

  vpg_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .inc       (adv),
    .count     (h_count),
    .count_nxt (h_nxt),
    .at_last   (h_last),
    .act_nxt   (h_act),
    .sync_nxt  (h_sync)
  );

  vpg_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .inc       (adv && h_last),
    .count     (v_count),
    .count_nxt (v_nxt),
    .at_last   (v_last),
    .act_nxt   (v_act),
    .sync_nxt  (v_sync)
  );

  assign last_px = h_last && v_last;

  // A re-raised enable on the last pixel of a stopping frame wraps straight into RUN.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        adv = 1'b1;
        if (!enable) begin
          if (last_px) begin
            state_nxt = IDLE;
            clr       = 1'b1;
          end else begin
            state_nxt = STOPPING;
          end
        end
      end
      STOPPING: begin
        adv = 1'b1;
        if (enable) begin
          state_nxt = RUN;
        end else if (last_px) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);
  assign fs_nxt   = (state_nxt == RUN) && (h_nxt == '0) && (v_nxt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
`ifdef VPG_TIMING_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      busy        <= busy_nxt;
      de          <= busy_nxt && h_act && v_act;
      frame_start <= fs_nxt;
      hsync       <= (busy_nxt && h_sync) ? HS_POL : ~HS_POL;
      vsync       <= (busy_nxt && v_sync) ? VS_POL : ~VS_POL;
`ifdef VPG_TIMING_FRAME_CNT_EN
      // The start strobe issued while leaving IDLE does not count as a new frame.
      if (fs_nxt && (state != IDLE)) frame_cnt <= frame_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_vpg_timing_gen.sv
// Directed bench for vpg_timing_gen with an 8x6 raster (48 clocks per frame).
// Build with `VPG_TIMING_FRAME_CNT_EN to also check frame_cnt at start strobes.
module tb_vpg_timing_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [11:0] h_count, v_count;
  logic        hsync, vsync, de, frame_start, busy;
`ifdef VPG_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  int          exp_fc;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vpg_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start),
    .busy        (busy)
`ifdef VPG_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs for raster position (h,v); bz=0 means the idle/reset picture.
  task automatic check_all(input string tag, input int h, input int v, input bit bz);
    logic e_de, e_hs, e_vs, e_fs;
    e_de = bz && (h < 4) && (v < 3);
    e_hs = (bz && h >= 5 && h <= 6) ? 1'b1 : 1'b0;
    e_vs = (bz && v == 4) ? 1'b0 : 1'b1;
    e_fs = bz && (h == 0) && (v == 0);
    chk({tag, ".h"},     16'(h_count),     16'(h));
    chk({tag, ".v"},     16'(v_count),     16'(v));
    chk({tag, ".busy"},  16'(busy),        16'(bz));
    chk({tag, ".de"},    16'(de),          16'(e_de));
    chk({tag, ".hsync"}, 16'(hsync),       16'(e_hs));
    chk({tag, ".vsync"}, 16'(vsync),       16'(e_vs));
    chk({tag, ".fs"},    16'(frame_start), 16'(e_fs));
`ifdef VPG_TIMING_FRAME_CNT_EN
    if (e_fs) chk({tag, ".frame_cnt"}, frame_cnt, 16'(exp_fc));
`endif
  endtask

  // Advance one clock and check the raster shows linear index idx (or idle).
  task automatic step_expect(input string tag, input int idx, input bit bz);
    @(posedge clk);
    #1;
    if (bz) check_all(tag, idx % 8, (idx / 8) % 6, 1'b1);
    else    check_all(tag, 0, 0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
`ifdef VPG_TIMING_FRAME_CNT_EN
    exp_fc = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) step_expect("idle", 0, 1'b0);

    // Start, one full frame and the next frame start 48 clocks later.
    enable = 1'b1;
    for (int i = 0; i < 48; i++) step_expect("run", i, 1'b1);
`ifdef VPG_TIMING_FRAME_CNT_EN
    exp_fc = 1;
`endif
    step_expect("run_wrap", 0, 1'b1);

    // Stop requested at (2,1): frame completes, then idle with no new strobe.
    for (int i = 1; i <= 10; i++) step_expect("run2", i, 1'b1);
    enable = 1'b0;
    for (int i = 11; i < 48; i++) step_expect("stopping", i, 1'b1);
    for (int i = 0; i < 6; i++) step_expect("idle_after_stop", 0, 1'b0);

    // Restart, stop at (2,1), re-raise at (5,3): next frame follows with no gap.
    enable = 1'b1;
    step_expect("restart", 0, 1'b1);
    for (int i = 1; i <= 10; i++) step_expect("restart_run", i, 1'b1);
    enable = 1'b0;
    for (int i = 11; i <= 29; i++) step_expect("stop_then_resume", i, 1'b1);
    enable = 1'b1;
    for (int i = 30; i < 48; i++) step_expect("resumed", i, 1'b1);
`ifdef VPG_TIMING_FRAME_CNT_EN
    exp_fc = 2;
`endif
    step_expect("no_gap_frame", 0, 1'b1);

    // Enable falls on the last pixel: straight to idle.
    for (int i = 1; i < 48; i++) step_expect("to_last", i, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step_expect("last_px_stop", 0, 1'b0);

    // Asynchronous reset at (6,4) while both syncs are active.
    enable = 1'b1;
    for (int i = 0; i <= 38; i++) step_expect("pre_reset", i, 1'b1);
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_hold", 0, 0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step_expect("post_reset_idle", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
